// File: rtl/sys1_clken_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sys1_clken_gen
//  Purpose  : NCH-channel fractional (DDA) clock-enable / toggle-clock
//             generator on clk48M with glitch-free runtime ratio updates.
//             Optional phase restart via `SYS1_CLKEN_SYNC_EN.
//  Revision : 1.0  initial release
// ============================================================================
module sys1_clken_gen #(
    parameter int NCH     = 4,
    parameter int ACCW    = 16,
    parameter int DEF_NUM = 1,
    parameter int DEF_DEN = 2,
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk48M,
    input  logic            reset_n,
    input  logic            run,
    input  logic            sync,
    input  logic            cfg_we,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [ACCW-1:0] cfg_num,
    input  logic [ACCW-1:0] cfg_den,
    output logic [NCH-1:0]  pend,
    output logic [NCH-1:0]  ce,
    output logic [NCH-1:0]  clk_out
);

    localparam logic [ACCW-1:0] c_DEF_NUM = ACCW'(DEF_NUM);
    localparam logic [ACCW-1:0] c_DEF_DEN = ACCW'(DEF_DEN);

    logic w_sync;
`ifdef SYS1_CLKEN_SYNC_EN
    assign w_sync = sync;
`else
    logic w_unused_sync;
    assign w_unused_sync = sync;
    assign w_sync        = 1'b0;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [ACCW-1:0] r_acc, r_num, r_den, r_sh_num, r_sh_den;
        logic            r_pend, r_ce, r_clk;
        logic [ACCW:0]   w_sum;
        logic            w_we, w_zero, w_go, w_hit, w_apply;

        // Out-of-range cfg_ch never matches any channel index.
        assign w_we    = cfg_we && (cfg_ch == CHW'(i));
        assign w_sum   = {1'b0, r_acc} + {1'b0, r_num};
        assign w_zero  = (r_num == '0) || (r_den == '0);
        assign w_go    = run && !w_zero;
        assign w_hit   = w_go && (w_sum >= {1'b0, r_den});
        assign w_apply = w_hit || w_zero || w_sync;

        always_ff @(posedge clk48M or negedge reset_n) begin
            if (!reset_n) begin
                r_acc    <= '0;
                r_num    <= c_DEF_NUM;
                r_den    <= c_DEF_DEN;
                r_sh_num <= c_DEF_NUM;
                r_sh_den <= c_DEF_DEN;
                r_pend   <= 1'b0;
                r_ce     <= 1'b0;
                r_clk    <= 1'b0;
            end else begin
                if (w_sync) begin
                    r_acc <= '0;
                    r_ce  <= 1'b0;
                    r_clk <= 1'b0;
                end else if (w_go) begin
                    r_ce <= w_hit;
                    if (w_hit)
                        r_clk <= ~r_clk;
                    // Result of acc+num-den always fits ACCW bits when num < den.
                    if (r_num >= r_den)
                        r_acc <= '0;
                    else if (w_hit)
                        r_acc <= r_acc + r_num - r_den;
                    else
                        r_acc <= w_sum[ACCW-1:0];
                end else begin
                    r_ce <= 1'b0;
                end

                // A write coinciding with an apply point bypasses the shadow.
                if (w_we && w_apply) begin
                    r_num <= cfg_num;
                    r_den <= cfg_den;
                end else if (w_apply && r_pend) begin
                    r_num <= r_sh_num;
                    r_den <= r_sh_den;
                end

                if (w_we) begin
                    r_sh_num <= cfg_num;
                    r_sh_den <= cfg_den;
                end

                if (w_we)
                    r_pend <= !w_apply;
                else if (w_apply)
                    r_pend <= 1'b0;
            end
        end

        assign pend[i]    = r_pend;
        assign ce[i]      = r_ce;
        assign clk_out[i] = r_clk;
    end

endmodule
`default_nettype wire
